// File: rtl/stream_pkg.sv
// Shared definitions for the width-converting stream blocks (serializer and
// the matching deserializer).
package stream_pkg;

   // Default narrow-side beat width used by the width converters.
   localparam int OUT_WIDTH_DEFAULT = 8;

   // Width of a beat counter that indexes `ratio` beats; never narrower than
   // one bit so the counter stays a legal vector for any ratio.
   function automatic int beat_idx_w(input int ratio);
      return ($clog2(ratio) > 1) ? $clog2(ratio) : 1;
   endfunction

endpackage

// File: rtl/stream_serializer.sv
// Wide-to-narrow stream serializer: accepts one DATA_WIDTH word per input
// handshake and replays it as DATA_WIDTH/OUT_WIDTH beats, least-significant
// slice first, with a last-beat marker. The next word loads on the same edge
// the last beat leaves, so a continuous stream has no bubbles.
module stream_serializer
   import stream_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_WIDTH  = OUT_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);

   localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
   localparam int IDX_W = beat_idx_w(RATIO);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

   // Reject parameter sets that cannot be split into at least two whole beats.
   if (((DATA_WIDTH % OUT_WIDTH) != 0) || (RATIO < 2)) begin : g_bad_params
      $error("stream_serializer: DATA_WIDTH must be a multiple of OUT_WIDTH with at least 2 beats");
   end

   // The holding register is viewed as an array of beats so the current
   // beat is a plain index instead of a computed bit offset.
   logic [RATIO-1:0][OUT_WIDTH-1:0] word_q, word_d;
   logic [IDX_W-1:0]                idx_q,  idx_d;
   logic                            full_q, full_d;

   logic in_fire;
   logic out_fire;

   assign out_valid = full_q;
   assign out_data  = word_q[idx_q];
   assign out_last  = full_q & (idx_q == LAST_IDX);
   // Room exists when empty, or when the last beat is leaving this cycle.
   assign in_ready  = ~full_q | (out_last & out_ready);

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // Next-state: advance the beat index on each output fire, drop to empty
   // after the last beat, and let an input fire (re)load the word.
   always_comb begin
      // NOTE: every _d gets its hold value first, so no path leaves a
      // variable unassigned and no latch is inferred.
      word_d = word_q;
      idx_d  = idx_q;
      full_d = full_q;

      if (out_fire) begin
         if (out_last) begin
            idx_d  = '0;
            full_d = 1'b0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end

      // An input fire only happens when empty or when the last beat leaves,
      // so it always starts a fresh word at beat 0.
      if (in_fire) begin
         word_d = in_data;
         idx_d  = '0;
         full_d = 1'b1;
      end
   end

   // State registers with synchronous reset taking priority over handshakes.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      if (rst) begin
         word_q <= '0;
         idx_q  <= '0;
         full_q <= 1'b0;
      end else begin
         word_q <= word_d;
         idx_q  <= idx_d;
         full_q <= full_d;
      end
   end

endmodule

// File: tb/tb_stream_serializer.sv
// Self-checking bench for stream_serializer: a beat-queue reference model is
// compared every cycle, directed scenarios pin literal beat sequences, and a
// random soak reassembles words from the emitted beats.
module tb_stream_serializer;

   localparam int DW    = 32;
   localparam int OW    = 8;
   localparam int RATIO = DW / OW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [OW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_last;

   stream_serializer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [OW-1:0] data;
      logic          last;
      int            cyc;
   } beat_t;

   beat_t         mq[$];      // beats still owed by the model, in order
   beat_t         beat_log[$];
   logic [DW-1:0] acc_log[$];
   int            acc_cyc[$];
   int            cyc = 0;
   int            n_checks = 0;
   int            n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs, compare against the model, advance model.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic rs);
      logic  exp_valid, exp_ready, exp_last, fin, fout;
      beat_t b;
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      rst       = rs;
      #1;
      exp_valid = (mq.size() != 0);
      exp_last  = exp_valid && mq[0].last;
      exp_ready = (mq.size() == 0) || (mq.size() == 1 && r);
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("in_ready",  32'(in_ready),  32'(exp_ready));
      check("out_last",  32'(out_last),  32'(exp_last));
      if (exp_valid) check("out_data", 32'(out_data), 32'(mq[0].data));

      if (rs) begin
         mq.delete();
      end else begin
         fout = exp_valid && r;
         fin  = v && exp_ready;
         if (fout) begin
            b     = mq.pop_front();
            b.cyc = cyc;
            beat_log.push_back(b);
         end
         if (fin) begin
            acc_log.push_back(d);
            acc_cyc.push_back(cyc);
            for (int i = 0; i < RATIO; i++)
               mq.push_back('{data: d[i*OW +: OW], last: (i == RATIO - 1), cyc: 0});
         end
      end
      cyc++;
   endtask

   task automatic clear_logs();
      beat_log.delete();
      acc_log.delete();
      acc_cyc.delete();
   endtask

   // Compare the beat log to a literal sequence (LSB-first bytes of `word_a`
   // then `word_b` when n == 8) and require contiguous cycles.
   task automatic expect_beats(input string name, input logic [DW-1:0] word_a,
                               input logic [DW-1:0] word_b, input int n);
      logic [2*DW-1:0] both;
      both = {word_b, word_a};
      check({name, "_count"}, 32'(beat_log.size()), 32'(n));
      for (int i = 0; i < n && i < beat_log.size(); i++) begin
         check({name, "_data"}, 32'(beat_log[i].data), 32'(both[i*OW +: OW]));
         check({name, "_last"}, 32'(beat_log[i].last), 32'((i % RATIO) == RATIO - 1));
         if (i > 0) check({name, "_gap"}, 32'(beat_log[i].cyc - beat_log[i-1].cyc), 32'd1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int            guard;
      logic [DW-1:0] w;
      logic [DW-1:0] asm_word;

      // Reset held with a word offered: nothing may be captured.
      clear_logs();
      step(1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
      step(1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_no_word",   32'(beat_log.size()), 32'd0);

      // Single word, free-running output.
      clear_logs();
      step(1'b1, 32'h12345678, 1'b1, 1'b0);
      for (int i = 0; i < RATIO; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
      expect_beats("single", 32'h12345678, 32'h0, 4);
      if (beat_log.size() > 0) check("single_latency", 32'(beat_log[0].cyc - acc_cyc[0]), 32'd1);
      check("single_b0", 32'(beat_log.size() > 0 ? beat_log[0].data : 8'h00), 32'h78);

      // Backpressure after beat 1: three stalled cycles.
      clear_logs();
      step(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
      step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
      step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
         check("bp_hold_data",  32'(out_data),  32'hA5);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready",   32'(in_ready),  32'd0);
      end
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check("bp_count", 32'(beat_log.size()), 32'd4);
      check("bp_words", 32'(acc_log.size()), 32'd1);
      if (beat_log.size() == 4) check("bp_last", 32'(beat_log[3].last), 32'd1);

      // Back-to-back words with in_valid held.
      clear_logs();
      step(1'b1, 32'h11223344, 1'b1, 1'b0);
      for (int i = 0; i < RATIO; i++) step(1'b1, 32'hAABBCCDD, 1'b1, 1'b0);
      for (int i = 0; i < RATIO; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
      expect_beats("b2b", 32'h11223344, 32'hAABBCCDD, 8);
      check("b2b_words", 32'(acc_log.size()), 32'd2);
      if (acc_log.size() == 2 && beat_log.size() == 8)
         check("b2b_accept_cyc", 32'(acc_cyc[1]), 32'(beat_log[3].cyc));

      // Reset after beat 2 discards the rest of the word.
      clear_logs();
      step(1'b1, 32'h0F1E2D3C, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready",  32'(in_ready),  32'd1);
      clear_logs();
      step(1'b1, 32'h000000FF, 1'b1, 1'b0);
      for (int i = 0; i < RATIO; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
      expect_beats("midrst", 32'h000000FF, 32'h0, 4);

      // Random soak: 1000 words under random valid/ready.
      clear_logs();
      guard = 0;
      while (acc_log.size() < 1000 && guard < 20000) begin
         w = $urandom();
         step(($urandom_range(0, 9) < 7), w, ($urandom_range(0, 9) < 7), 1'b0);
         guard++;
      end
      check("soak_words_accepted", 32'(acc_log.size() >= 1000), 32'd1);
      guard = 0;
      while (mq.size() != 0 && guard < 100) begin
         step(1'b0, 32'h0, 1'b1, 1'b0);
         guard++;
      end
      check("soak_drained", 32'(mq.size()), 32'd0);
      check("soak_beat_count", 32'(beat_log.size()), 32'(acc_log.size() * RATIO));
      for (int wi = 0; wi < acc_log.size() && (wi + 1) * RATIO <= beat_log.size(); wi++) begin
         int n_last;
         asm_word = '0;
         n_last   = 0;
         for (int b = 0; b < RATIO; b++) begin
            asm_word[b*OW +: OW] = beat_log[wi*RATIO + b].data;
            if (beat_log[wi*RATIO + b].last) n_last++;
         end
         check("soak_reassembly", asm_word, acc_log[wi]);
         check("soak_one_last",   32'(n_last), 32'd1);
         check("soak_last_pos",   32'(beat_log[wi*RATIO + RATIO - 1].last), 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
